// File: rtl/rf_read_stage_if.sv
// Read-stage bus: register-array read port, write-back snoop and operand handshake.
interface rf_read_stage_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREGS = 16
);
    localparam int unsigned IDW = $clog2(NREGS);

    logic             in_valid;
    logic             in_ready;
    logic [IDW-1:0]   SrcReg1;
    logic [IDW-1:0]   SrcReg2;
    logic [NREGS-1:0] ReadEnable1;
    logic [NREGS-1:0] ReadEnable2;
    logic [WIDTH-1:0] Bitline1;
    logic [WIDTH-1:0] Bitline2;
    logic             WriteReg;
    logic [IDW-1:0]   DstReg;
    logic [WIDTH-1:0] DstData;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] SrcData1;
    logic [WIDTH-1:0] SrcData2;

    // Stage side
    modport slave (
        input  in_valid, SrcReg1, SrcReg2, Bitline1, Bitline2,
               WriteReg, DstReg, DstData, out_ready,
        output in_ready, ReadEnable1, ReadEnable2, out_valid, SrcData1, SrcData2
    );

    // Upstream / register array / execute side
    modport master (
        output in_valid, SrcReg1, SrcReg2, Bitline1, Bitline2,
               WriteReg, DstReg, DstData, out_ready,
        input  in_ready, ReadEnable1, ReadEnable2, out_valid, SrcData1, SrcData2
    );
endinterface

// File: rtl/rf_read_stage.sv
// Register-file read stage: one-hot read decode, write bypass, zero register,
// and a head + skid operand queue whose held entries snoop write-back.
module rf_read_stage #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned NREGS    = 16,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    rf_read_stage_if.slave bus
);
    localparam int unsigned IDW = $clog2(NREGS);

    typedef struct packed {
        logic [IDW-1:0]   id1;
        logic [IDW-1:0]   id2;
        logic [WIDTH-1:0] d1;
        logic [WIDTH-1:0] d2;
    } entry_t;

    logic   head_v, skid_v;
    entry_t head_q, skid_q;
    logic   head_v_d, skid_v_d;
    entry_t head_d, skid_d;
    entry_t new_e, head_s, skid_s;
    logic   accept, pop;

    function automatic logic is_zero(input logic [IDW-1:0] id);
        return (ZERO_REG != 0) && (id == '0);
    endfunction

    // Operand for a fresh read: zero register, then same-cycle write, then bitline
    function automatic logic [WIDTH-1:0] pick(input logic [IDW-1:0] id,
                                              input logic [WIDTH-1:0] bl,
                                              input logic wr,
                                              input logic [IDW-1:0] dst,
                                              input logic [WIDTH-1:0] dd);
        if (is_zero(id))
            return '0;
        if (wr && (dst == id))
            return dd;
        return bl;
    endfunction

    // Refresh a held operand when its source register is being written
    function automatic logic [WIDTH-1:0] snoop(input logic [IDW-1:0] id,
                                               input logic [WIDTH-1:0] d,
                                               input logic wr,
                                               input logic [IDW-1:0] dst,
                                               input logic [WIDTH-1:0] dd);
        if (wr && (dst == id) && !is_zero(id))
            return dd;
        return d;
    endfunction

    // in_ready comes straight from the skid flop, so out_ready never reaches it
    assign bus.in_ready  = !skid_v;
    assign accept        = rst && bus.in_valid && !skid_v;
    assign pop           = head_v && bus.out_ready;

    assign bus.ReadEnable1 = accept ? (NREGS'(1) << bus.SrcReg1) : '0;
    assign bus.ReadEnable2 = accept ? (NREGS'(1) << bus.SrcReg2) : '0;

    assign bus.out_valid = head_v;
    assign bus.SrcData1  = head_q.d1;
    assign bus.SrcData2  = head_q.d2;

    // Entry formed from the request being accepted this cycle
    always_comb begin
        new_e     = '0;
        new_e.id1 = bus.SrcReg1;
        new_e.id2 = bus.SrcReg2;
        new_e.d1  = pick(bus.SrcReg1, bus.Bitline1, bus.WriteReg, bus.DstReg, bus.DstData);
        new_e.d2  = pick(bus.SrcReg2, bus.Bitline2, bus.WriteReg, bus.DstReg, bus.DstData);
    end

    // Held entries with this cycle's write-back applied
    always_comb begin
        head_s    = head_q;
        skid_s    = skid_q;
        head_s.d1 = snoop(head_q.id1, head_q.d1, bus.WriteReg, bus.DstReg, bus.DstData);
        head_s.d2 = snoop(head_q.id2, head_q.d2, bus.WriteReg, bus.DstReg, bus.DstData);
        skid_s.d1 = snoop(skid_q.id1, skid_q.d1, bus.WriteReg, bus.DstReg, bus.DstData);
        skid_s.d2 = snoop(skid_q.id2, skid_q.d2, bus.WriteReg, bus.DstReg, bus.DstData);
    end

    // Queue movement: pop shifts skid to head, accept fills the first free slot
    always_comb begin
        head_v_d = head_v;
        skid_v_d = skid_v;
        head_d   = head_s;
        skid_d   = skid_s;
        if (pop) begin
            if (skid_v) begin
                head_d   = skid_s;
                skid_v_d = accept;
                if (accept)
                    skid_d = new_e;
            end else begin
                head_v_d = accept;
                if (accept)
                    head_d = new_e;
            end
        end else if (accept) begin
            if (head_v) begin
                skid_v_d = 1'b1;
                skid_d   = new_e;
            end else begin
                head_v_d = 1'b1;
                head_d   = new_e;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_v <= 1'b0;
            skid_v <= 1'b0;
            head_q <= '0;
            skid_q <= '0;
        end else begin
            head_v <= head_v_d;
            skid_v <= skid_v_d;
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end
endmodule

// File: tb/tb_rf_read_stage.sv
// Scoreboard bench for rf_read_stage against an architectural register-file model.
module tb_rf_read_stage;
    localparam int unsigned W = 16;
    localparam int unsigned N = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rf_read_stage_if #(.WIDTH(W), .NREGS(N)) bus();
    rf_read_stage #(.WIDTH(W), .NREGS(N), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } req_t;

    req_t        exp_mem [256];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [15:0] regs [16];
    logic        exp_ready;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Architectural value of a register: R0 is hardwired to zero
    function automatic logic [15:0] arch(input logic [3:0] r);
        return (r == 4'd0) ? 16'h0000 : regs[r];
    endfunction

    // Register array: bitlines show the enabled row, junk when nothing is enabled
    always_comb begin
        bus.Bitline1 = 16'hDEAD;
        bus.Bitline2 = 16'hBEAD;
        for (int i = 0; i < 16; i++) begin
            if (bus.ReadEnable1[i]) bus.Bitline1 = regs[i];
            if (bus.ReadEnable2[i]) bus.Bitline2 = regs[i];
        end
    end

    // Array write and scoreboard push on every accepted request
    always @(posedge clk) begin
        if (bus.WriteReg)
            regs[bus.DstReg] <= bus.DstData;
        if (rst && bus.in_valid && exp_ready) begin
            exp_mem[wr_ptr % 256] <= req_t'{bus.SrcReg1, bus.SrcReg2};
            wr_ptr <= wr_ptr + 1;
        end
    end

    // Monitor: handshake, enables and operand values against the model
    always @(negedge clk) begin
        int          occ;
        logic [15:0] e1, e2;
        req_t        h;
        if (!rst) begin
            rd_ptr    = wr_ptr;
            exp_ready = 1'b1;
        end else begin
            occ       = wr_ptr - rd_ptr;
            exp_ready = (occ < 2);
            check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
            check("out_valid", 32'(bus.out_valid), 32'(occ != 0));
            e1 = (bus.in_valid && exp_ready) ? (16'(1) << bus.SrcReg1) : 16'h0000;
            e2 = (bus.in_valid && exp_ready) ? (16'(1) << bus.SrcReg2) : 16'h0000;
            check("read_enable1", 32'(bus.ReadEnable1), 32'(e1));
            check("read_enable2", 32'(bus.ReadEnable2), 32'(e2));
            if (occ != 0) begin
                h = exp_mem[rd_ptr % 256];
                check("src_data1", 32'(bus.SrcData1), 32'(arch(h.a)));
                check("src_data2", 32'(bus.SrcData2), 32'(arch(h.b)));
                if (bus.out_ready)
                    rd_ptr = rd_ptr + 1;
            end
        end
    end

    task automatic step(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic w, input logic [3:0] d, input logic [15:0] dd,
                        input logic ordy);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.SrcReg1   = s1;
        bus.SrcReg2   = s2;
        bus.WriteReg  = w;
        bus.DstReg    = d;
        bus.DstData   = dd;
        bus.out_ready = ordy;
    endtask

    // Present a request and hold it until the model says it is taken
    task automatic send(input logic [3:0] s1, input logic [3:0] s2, input logic w,
                        input logic [3:0] d, input logic [15:0] dd, input logic ordy);
        bit taken = 1'b0;
        step(1'b1, s1, s2, w, d, dd, ordy);
        for (int k = 0; k < 20 && !taken; k++) begin
            @(negedge clk);
            #1;
            taken = exp_ready;
        end
        if (!taken) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=stalled expected=accepted");
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int k = 0; k < n; k++)
            step(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, ordy);
    endtask

    initial begin
        logic [15:0] v;
        bus.in_valid  = 1'b0;
        bus.SrcReg1   = 4'd0;
        bus.SrcReg2   = 4'd0;
        bus.WriteReg  = 1'b0;
        bus.DstReg    = 4'd0;
        bus.DstData   = 16'h0000;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_enable", 32'(bus.ReadEnable1), 32'd0);
        check("rst_src_data1", 32'(bus.SrcData1), 32'd0);
        bus.in_valid = 1'b0;
        rst = 1'b1;

        // Preload the array through its write port
        for (int i = 0; i < 16; i++) begin
            case (i)
                0:       v = 16'hFFFF;
                3:       v = 16'h1234;
                5:       v = 16'hBEEF;
                7:       v = 16'h0001;
                default: v = 16'($urandom);
            endcase
            step(1'b0, 4'd0, 4'd0, 1'b1, 4'(i), v, 1'b1);
        end

        // Plain read of R3/R5
        send(4'd3, 4'd5, 1'b0, 4'd0, 16'h0000, 1'b1);
        check("t1_enable1", 32'(bus.ReadEnable1), 32'h0008);
        check("t1_enable2", 32'(bus.ReadEnable2), 32'h0020);
        idle(1, 1'b1);
        @(negedge clk);
        #1;
        check("t1_data1", 32'(bus.SrcData1), 32'h1234);
        check("t1_data2", 32'(bus.SrcData2), 32'hBEEF);

        // Same-cycle write bypass
        send(4'd3, 4'd3, 1'b1, 4'd3, 16'h00AA, 1'b1);
        idle(1, 1'b1);
        @(negedge clk);
        #1;
        check("t2_bypass", 32'(bus.SrcData2), 32'h00AA);

        // Zero register ignores bitlines and writes
        send(4'd0, 4'd0, 1'b1, 4'd0, 16'h5555, 1'b1);
        idle(1, 1'b1);
        @(negedge clk);
        #1;
        check("t3_zero", 32'(bus.SrcData1), 32'h0000);

        // Fill under stall, third request waits, then drain in order
        send(4'd1, 4'd2, 1'b0, 4'd0, 16'h0000, 1'b0);
        send(4'd4, 4'd6, 1'b0, 4'd0, 16'h0000, 1'b0);
        repeat (3) step(1'b1, 4'd8, 4'd9, 1'b0, 4'd0, 16'h0000, 1'b0);
        send(4'd8, 4'd9, 1'b0, 4'd0, 16'h0000, 1'b1);
        idle(4, 1'b1);

        // Snoop updates the stalled head
        send(4'd7, 4'd9, 1'b0, 4'd0, 16'h0000, 1'b0);
        idle(1, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b1, 4'd7, 16'h7777, 1'b0);
        idle(2, 1'b0);
        check("t5_snoop", 32'(bus.SrcData1), 32'h7777);
        idle(3, 1'b1);

        // Asynchronous reset with both entries full
        send(4'd1, 4'd2, 1'b0, 4'd0, 16'h0000, 1'b0);
        send(4'd3, 4'd4, 1'b0, 4'd0, 16'h0000, 1'b0);
        step(1'b1, 4'd5, 4'd6, 1'b0, 4'd0, 16'h0000, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        check("t6_out_valid", 32'(bus.out_valid), 32'd0);
        check("t6_src_data1", 32'(bus.SrcData1), 32'd0);
        check("t6_src_data2", 32'(bus.SrcData2), 32'd0);
        check("t6_in_ready", 32'(bus.in_ready), 32'd1);
        check("t6_enable", 32'(bus.ReadEnable1), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        idle(3, 1'b1);

        // Random traffic
        for (int k = 0; k < 400; k++)
            step(1'($urandom_range(0, 9) < 7), 4'($urandom), 4'($urandom),
                 1'($urandom_range(0, 9) < 4), 4'($urandom), 16'($urandom),
                 1'($urandom_range(0, 9) < 6));
        idle(5, 1'b1);
        @(negedge clk);
        #1;
        check("drained", 32'(bus.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rf_read_stage.md
Name: rf_read_stage

Overview:
- Read-port stage directly downstream of the 16-entry register array.
- Decodes two source register IDs into one-hot read enables that drive the register array's ReadEnable1/ReadEnable2, and samples the shared Bitline1/Bitline2 buses.
- Applies write-to-read bypass and an optional hardwired-zero register.
- Presents operands to the execute stage through a registered valid/ready interface with a 2-entry skid buffer.

Parameters:
- WIDTH, 16, data width of the bitlines and operands.
- NREGS, 16, number of registers; the ID width is log2(NREGS) = 4.
- ZERO_REG, 1, when 1 register 0 always reads as 0 and is never bypassed.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream read request valid.
- in_ready  out  1  stage can accept a request.
- SrcReg1  in  4  source register ID, port 1.
- SrcReg2  in  4  source register ID, port 2.
- ReadEnable1  out  16  one-hot read select to the register array, port 1.
- ReadEnable2  out  16  one-hot read select to the register array, port 2.
- Bitline1  in  16  read data from the register array, port 1.
- Bitline2  in  16  read data from the register array, port 2.
- WriteReg  in  1  write-back strobe (the same signal the register array sees).
- DstReg  in  4  write-back register ID.
- DstData  in  16  write-back data.
- out_valid  out  1  operands valid.
- out_ready  in  1  downstream accepts the operands.
- SrcData1  out  16  operand 1.
- SrcData2  out  16  operand 2.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, SrcData1/2=0, both skid entries invalid, in_ready=1.
  - ReadEnable1/2 = 0 while rst=0, so the bitlines are undriven.
- Decode (combinational):
  - ReadEnableN = (1 << SrcRegN) when in_valid && in_ready, else 0.
  - At most one bit of each enable is set.
- Operand select at accept time, in priority order:
  1. ZERO_REG && SrcRegN==0 -> 0.
  2. WriteReg && DstReg==SrcRegN -> DstData (bypass; the array write lands only at the edge).
  3. Otherwise BitlineN.
- Accept: a request is accepted when in_valid && in_ready.
  - The selected operands and the source IDs enter the queue at the clock edge.
  - Latency is 1 cycle: an accept in cycle t makes data visible on SrcData at t+1 if the queue was empty.
- Queue structure:
  - Output register (head) plus one skid entry.
  - in_ready = !skid_valid, registered, so there is no combinational out_ready->in_ready path.
- Pop: head is consumed when out_valid && out_ready.
  - On pop, the skid entry (if valid) moves to the head.
  - On a simultaneous accept, the new entry goes to the skid if a skid entry was shifted, else to the head.
- Push/pop rules:
  - Full (head and skid both valid): in_ready=0 and no enables are driven.
  - Simultaneous push and pop while full is impossible because in_ready=0.
  - Push and pop with only the head valid: the new entry goes to the head and the skid stays empty.
- Held-entry snoop: every cycle WriteReg is high, each valid queued entry compares DstReg to its stored source IDs.
  - On a match (and not the zero register when ZERO_REG=1), the stored operand is replaced with DstData at the edge.
  - This applies to the head even while out_valid=1 && out_ready=0.
  - Both operands of one entry update together if both match.
- Data stability: while out_valid=1 && out_ready=0, SrcData changes only through the snoop update.
- Reset mid-operation: all entries are dropped immediately and no partial output is kept.

Test Plan:
1. Preload R3=0x1234 and R5=0xBEEF; request Src1=3, Src2=5 with out_ready=1 -> ReadEnable1=0x0008 and ReadEnable2=0x0020 in the accept cycle; next cycle out_valid=1, SrcData1=0x1234, SrcData2=0xBEEF.
2. Same cycle WriteReg=1, DstReg=3, DstData=0x00AA; request Src1=3, Src2=3 -> SrcData1=SrcData2=0x00AA (bypass wins over the stale bitline).
3. ZERO_REG=1, R0 bitlines forced to 0xFFFF, WriteReg to R0=0x5555; request Src1=0 -> SrcData1=0x0000.
4. out_ready=0 with three back-to-back requests -> the first two are accepted; in_ready=0 from the cycle after the second accept; the third stalls with enables=0; raise out_ready -> results emerge in request order with no loss or duplication.
5. Head holds Src1=7 (0x0001) under stall; WriteReg, DstReg=7, DstData=0x7777 -> SrcData1 becomes 0x7777 the next cycle while out_valid stays 1.
6. Assert rst=0 with both entries valid -> out_valid=0, SrcData=0, in_ready=1 immediately, without waiting for clk.
